// File: rtl/icache_line_fill.sv
// Line-fill engine behind the instruction cache: on a miss it acquires the memory bus, bursts
// an aligned line from memory and replays each word as a fill write. Option: ICACHE_CRITICAL_WORD_FIRST_EN.
`timescale 1ns/1ps

module icache_line_fill #(
   parameter int unsigned PADD_SIZE  = 24,
   parameter int unsigned DATA_SIZE  = 32,
   parameter int unsigned CMD_SIZE   = 3,
   parameter int unsigned BURST_LEN  = 4,
   parameter int unsigned BURST_LOG2 = 2,
   parameter int unsigned TIMEOUT    = 255,
   parameter int unsigned TIMER_W    = 8
) (
   input  logic                 clk0,
   input  logic                 reset,
   input  logic                 miss_req,
   input  logic [PADD_SIZE-1:0] miss_addr,
   input  logic                 bus_grant,
   output logic                 bus_request,
   output logic [PADD_SIZE-1:0] mem_addr,
   output logic [CMD_SIZE-1:0]  mem_cmd,
   input  logic [DATA_SIZE-1:0] mem_datain,
   input  logic                 mem_ready,
   output logic                 fill_valid,
   output logic [PADD_SIZE-1:0] fill_addr,
   output logic [CMD_SIZE-1:0]  fill_cmd,
   output logic [DATA_SIZE-1:0] fill_data,
   output logic                 busy,
   output logic                 timeout_err
);

   localparam logic [CMD_SIZE-1:0]   CMD_IDLE   = CMD_SIZE'(0);
   localparam logic [CMD_SIZE-1:0]   CMD_READ   = CMD_SIZE'(1);
   localparam logic [CMD_SIZE-1:0]   CMD_WRITE  = CMD_SIZE'(2);
   localparam logic [PADD_SIZE-1:0]  LINE_MASK  = ~PADD_SIZE'(BURST_LEN - 1);
   localparam logic [TIMER_W-1:0]    TIMER_LAST = TIMER_W'(TIMEOUT - 1);
   localparam logic [BURST_LOG2-1:0] COUNT_LAST = BURST_LOG2'(BURST_LEN - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_RD,
      S_FILL,
      S_DONE,
      S_ERR
   } state_t;

   state_t                state;
   logic [PADD_SIZE-1:0]  base;
   logic [BURST_LOG2-1:0] count;
   logic [BURST_LOG2-1:0] count_nxt;
   logic [TIMER_W-1:0]    timer;
   logic                  last_word;
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
   logic [BURST_LOG2-1:0] start_off;
`endif

   function automatic logic [PADD_SIZE-1:0] word_addr(input logic [PADD_SIZE-1:0] b,
                                                      input logic [BURST_LOG2-1:0] c);
      return b | PADD_SIZE'(c);
   endfunction

   // The burst ends once every word of the line has been filled exactly once.
   always_comb begin
      count_nxt = count + BURST_LOG2'(1);
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
      last_word = (count_nxt == start_off);
`else
      last_word = (count == COUNT_LAST);
`endif
   end

   always_ff @(posedge clk0 or posedge reset) begin
      if (reset) begin
         state       <= S_IDLE;
         base        <= '0;
         count       <= '0;
         timer       <= '0;
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
         start_off   <= '0;
`endif
         bus_request <= 1'b0;
         mem_addr    <= '0;
         mem_cmd     <= CMD_IDLE;
         fill_valid  <= 1'b0;
         fill_addr   <= '0;
         fill_cmd    <= CMD_IDLE;
         fill_data   <= '0;
         busy        <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         fill_valid  <= 1'b0;
         fill_cmd    <= CMD_IDLE;
         timeout_err <= 1'b0;
         mem_cmd     <= CMD_IDLE;
         mem_addr    <= '0;

         case (state)
            S_IDLE: begin
               if (miss_req) begin
                  base        <= miss_addr & LINE_MASK;
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
                  count       <= miss_addr[BURST_LOG2-1:0];
                  start_off   <= miss_addr[BURST_LOG2-1:0];
`else
                  count       <= '0;
`endif
                  timer       <= '0;
                  state       <= S_REQ;
                  bus_request <= 1'b1;
                  busy        <= 1'b1;
               end
            end

            S_REQ: begin
               timer <= '0;
               if (bus_grant) begin
                  state    <= S_RD;
                  mem_cmd  <= CMD_READ;
                  mem_addr <= word_addr(base, count);
               end
            end

            // Data beats grant loss, which beats the timeout.
            S_RD: begin
               if (mem_ready) begin
                  fill_data  <= mem_datain;
                  timer      <= '0;
                  state      <= S_FILL;
                  fill_valid <= 1'b1;
                  fill_cmd   <= CMD_WRITE;
                  fill_addr  <= word_addr(base, count);
               end else if (!bus_grant) begin
                  timer <= '0;
                  state <= S_REQ;
               end else if (timer == TIMER_LAST) begin
                  timer       <= '0;
                  state       <= S_ERR;
                  timeout_err <= 1'b1;
                  bus_request <= 1'b0;
               end else begin
                  timer    <= timer + TIMER_W'(1);
                  mem_cmd  <= CMD_READ;
                  mem_addr <= word_addr(base, count);
               end
            end

            S_FILL: begin
               if (last_word) begin
                  state       <= S_DONE;
                  bus_request <= 1'b0;
               end else begin
                  count    <= count_nxt;
                  state    <= S_RD;
                  mem_cmd  <= CMD_READ;
                  mem_addr <= word_addr(base, count_nxt);
               end
            end

            S_DONE: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end

            S_ERR: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end

            default: begin
               state       <= S_IDLE;
               bus_request <= 1'b0;
               busy        <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_icache_line_fill.sv
// Directed bench for icache_line_fill: table of clean bursts plus hand-written grant-drop,
// timeout and mid-burst reset sequences. Memory returns {8'hD0, address} as data.
`timescale 1ns/1ps

module tb_icache_line_fill;

   logic        clk0 = 1'b0;
   logic        reset;
   logic        miss_req;
   logic [23:0] miss_addr;
   logic        bus_grant;
   logic        bus_request;
   logic [23:0] mem_addr;
   logic [2:0]  mem_cmd;
   logic [31:0] mem_datain;
   logic        mem_ready;
   logic        fill_valid;
   logic [23:0] fill_addr;
   logic [2:0]  fill_cmd;
   logic [31:0] fill_data;
   logic        busy;
   logic        timeout_err;
   logic        ready_en;
   logic [89:0] all_out;

   int total_cnt = 0;
   int bad_cnt   = 0;

   icache_line_fill #(
      .PADD_SIZE(24), .DATA_SIZE(32), .CMD_SIZE(3), .BURST_LEN(4),
      .BURST_LOG2(2), .TIMEOUT(255), .TIMER_W(8)
   ) dut (
      .clk0(clk0), .reset(reset), .miss_req(miss_req), .miss_addr(miss_addr),
      .bus_grant(bus_grant), .bus_request(bus_request), .mem_addr(mem_addr),
      .mem_cmd(mem_cmd), .mem_datain(mem_datain), .mem_ready(mem_ready),
      .fill_valid(fill_valid), .fill_addr(fill_addr), .fill_cmd(fill_cmd),
      .fill_data(fill_data), .busy(busy), .timeout_err(timeout_err)
   );

   always #5 clk0 = ~clk0;

   assign mem_datain = {8'hD0, mem_addr};
   assign mem_ready  = ready_en && (mem_cmd == 3'b001);
   assign all_out    = {bus_request, mem_addr, mem_cmd, fill_valid, fill_addr,
                        fill_cmd, fill_data, busy, timeout_err};

   typedef struct {
      logic [23:0]       addr;
      int                gdly;
      int                first;
      bit                hold;
      logic [3:0][23:0]  exp;
   } vec_t;

   vec_t vecs [4];
   vec_t rst_vec;

   function automatic vec_t mk(input logic [23:0] addr, input int gdly, input int first,
                               input bit hold, input logic [23:0] a0, input logic [23:0] a1,
                               input logic [23:0] a2, input logic [23:0] a3);
      vec_t v;
      v.addr = addr; v.gdly = gdly; v.first = first; v.hold = hold;
      v.exp[0] = a0; v.exp[1] = a1; v.exp[2] = a2; v.exp[3] = a3;
      return v;
   endfunction

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      total_cnt++;
      if (act !== exp) begin
         bad_cnt++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // Clean burst: grant after gdly cycles, memory always ready.
   task automatic run_burst(input vec_t v);
      int   n = 0;
      logic cmd_ok = 1'b1;
      logic wait_ok = 1'b1;
      miss_addr = v.addr;
      miss_req  = 1'b1;
      bus_grant = (v.gdly == 0);
      ready_en  = 1'b1;
      for (int c = 1; c <= v.first + 8; c++) begin
         @(negedge clk0);
         if (c == 1) begin
            miss_req  = v.hold;
            miss_addr = 24'hFFFFFF;
         end
         if (c <= v.gdly && !(bus_request && mem_cmd == 3'b000 && !fill_valid)) wait_ok = 1'b0;
         if (c == v.gdly) bus_grant = 1'b1;
         if (fill_valid) begin
            if (n < 4) begin
               check("fill_addr", 128'(fill_addr), 128'(v.exp[n]));
               check("fill_data", 128'(fill_data), 128'({8'hD0, v.exp[n]}));
               check("fill_cycle", 128'(c), 128'(v.first + 2 * n));
               if (fill_cmd != 3'b010) cmd_ok = 1'b0;
            end
            n++;
         end else if (fill_cmd != 3'b000) begin
            cmd_ok = 1'b0;
         end
         if (c == v.first + 7) check("done_busy_breq", 128'({busy, bus_request}), 128'(2'b10));
         if (c == v.first + 8) check("idle_busy", 128'(busy), 128'(0));
      end
      check("fill_count", 128'(n), 128'(4));
      check("fill_cmd", 128'(cmd_ok), 128'(1));
      if (v.gdly > 0) check("grant_wait", 128'(wait_ok), 128'(1));
      if (v.hold) begin
         @(negedge clk0);
         check("hold_restart", 128'(busy), 128'(1));
         miss_req = 1'b0;
         for (int c = 0; c < 40; c++) begin
            @(negedge clk0);
            if (!busy) break;
         end
         check("hold_drain", 128'(busy), 128'(0));
      end
      miss_req = 1'b0;
   endtask

   initial begin
      int   n;
      int   dropped;
      int   rd_c;
      int   to_c;
      int   fills;
      logic got_reissue;
      logic quiet;
      logic [23:0] reissue_addr;

`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
      vecs[0] = mk(24'h001236, 0, 3, 1'b0, 24'h001236, 24'h001237, 24'h001234, 24'h001235);
      vecs[1] = mk(24'h00ABC0, 10, 12, 1'b0, 24'h00ABC0, 24'h00ABC1, 24'h00ABC2, 24'h00ABC3);
      vecs[2] = mk(24'hFFFFFF, 1, 3, 1'b0, 24'hFFFFFF, 24'hFFFFFC, 24'hFFFFFD, 24'hFFFFFE);
      vecs[3] = mk(24'h000003, 0, 3, 1'b1, 24'h000003, 24'h000000, 24'h000001, 24'h000002);
      rst_vec = mk(24'h000042, 0, 3, 1'b0, 24'h000042, 24'h000043, 24'h000040, 24'h000041);
`else
      vecs[0] = mk(24'h001236, 0, 3, 1'b0, 24'h001234, 24'h001235, 24'h001236, 24'h001237);
      vecs[1] = mk(24'h00ABC0, 10, 12, 1'b0, 24'h00ABC0, 24'h00ABC1, 24'h00ABC2, 24'h00ABC3);
      vecs[2] = mk(24'hFFFFFF, 1, 3, 1'b0, 24'hFFFFFC, 24'hFFFFFD, 24'hFFFFFE, 24'hFFFFFF);
      vecs[3] = mk(24'h000003, 0, 3, 1'b1, 24'h000000, 24'h000001, 24'h000002, 24'h000003);
      rst_vec = mk(24'h000042, 0, 3, 1'b0, 24'h000040, 24'h000041, 24'h000042, 24'h000043);
`endif

      reset = 1'b1; miss_req = 1'b0; miss_addr = 24'h0; bus_grant = 1'b0; ready_en = 1'b0;
      repeat (3) @(negedge clk0);
      check("reset_outputs", 128'(all_out), 128'(0));
      reset = 1'b0;
      @(negedge clk0);

      for (int i = 0; i < 4; i++) run_burst(vecs[i]);

      // Grant lost while word 2 is outstanding: same word must be re-requested.
      miss_addr = 24'h00A0F0; miss_req = 1'b1; bus_grant = 1'b1; ready_en = 1'b1;
      n = 0; dropped = 0; got_reissue = 1'b0; reissue_addr = 24'h0;
      for (int c = 1; c <= 60; c++) begin
         @(negedge clk0);
         if (c == 1) miss_req = 1'b0;
         if (dropped == 1) begin
            check("drop_back_to_req", 128'({bus_request, mem_cmd}), 128'(4'b1000));
            bus_grant = 1'b1; ready_en = 1'b1; dropped = 2;
         end else if (dropped == 2 && !got_reissue && mem_cmd == 3'b001) begin
            reissue_addr = mem_addr; got_reissue = 1'b1;
         end
         if (dropped == 0 && mem_cmd == 3'b001 && mem_addr == 24'h00A0F2) begin
            bus_grant = 1'b0; ready_en = 1'b0; dropped = 1;
         end
         if (fill_valid) begin
            if (n < 4) check("drop_fill_addr", 128'(fill_addr), 128'(24'h00A0F0 + 24'(n)));
            n++;
         end
         if (c > 3 && !busy) break;
      end
      check("drop_reissue_addr", 128'(reissue_addr), 128'(24'h00A0F2));
      check("drop_fill_count", 128'(n), 128'(4));
      check("drop_idle", 128'(busy), 128'(0));

      // Memory never answers: abort after 255 cycles in RD.
      miss_addr = 24'h000100; miss_req = 1'b1; bus_grant = 1'b1; ready_en = 1'b0;
      rd_c = -1; to_c = -1; fills = 0;
      for (int c = 1; c <= 400; c++) begin
         @(negedge clk0);
         if (c == 1) miss_req = 1'b0;
         if (mem_cmd == 3'b001 && rd_c < 0) rd_c = c;
         if (fill_valid) fills++;
         if (timeout_err && to_c < 0) begin
            to_c = c;
            check("timeout_breq", 128'({bus_request, busy}), 128'(2'b01));
         end else if (to_c > 0 && c == to_c + 1) begin
            check("timeout_pulse_idle", 128'({timeout_err, busy}), 128'(0));
            break;
         end
      end
      check("timeout_delay", 128'(to_c - rd_c), 128'(255));
      check("timeout_no_fill", 128'(fills), 128'(0));
      ready_en = 1'b1;

      // Reset in the middle of a burst, then a fresh miss.
      miss_addr = 24'h000040; miss_req = 1'b1; bus_grant = 1'b1; n = 0;
      for (int c = 1; c <= 30; c++) begin
         @(negedge clk0);
         if (c == 1) miss_req = 1'b0;
         if (fill_valid) n++;
         if (n == 2) break;
      end
      check("pre_reset_fills", 128'(n), 128'(2));
      #2 reset = 1'b1;
      #1 check("midburst_reset_outputs", 128'(all_out), 128'(0));
      @(negedge clk0);
      reset = 1'b0;
      quiet = 1'b1;
      repeat (4) begin
         @(negedge clk0);
         if (busy || fill_valid || bus_request) quiet = 1'b0;
      end
      check("post_reset_quiet", 128'(quiet), 128'(1));
      run_burst(rst_vec);

      $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
      $finish;
   end

endmodule
